// File: rtl/pipe_stage_chain.sv
// pipe_stage_chain
//   A DEPTH-deep chain of data registers, each with a valid flag. The chain
//   advances on an active-low enable, holds when the enable is high, and can be
//   flushed so that every stage is loaded with NOP_VAL and marked invalid.
//   Occupancy (number of valid stages) is tracked incrementally as a register.
//
// Parameters
//   WIDTH   : data bits per stage (1..64)
//   DEPTH   : number of register stages (1..8)
//   NOP_VAL : value loaded into every stage on flush
//
// Ports
//   clk       : clock, all state changes on rising edge
//   clrn      : asynchronous active-low reset (data/valid/occ/stall -> 0)
//   we        : advance enable, active-low (0 = advance, 1 = hold)
//   flush     : active-high, invalidates all stages (overrides we)
//   d         : data into stage 0
//   d_valid   : valid flag accompanying d
//   q         : data of the last stage
//   q_valid   : valid flag of the last stage
//   occ       : number of valid stages (0..DEPTH)
//   stall_cnt : saturating count of stalled cycles with a non-empty chain
//
// Build option
//   PIPE_STALL_CNT_EN : when defined, builds the stall counter; otherwise
//                       stall_cnt is tied to zero.

module pipe_stage_chain #(
  parameter int unsigned      WIDTH   = 32,
  parameter int unsigned      DEPTH   = 2,
  parameter logic [WIDTH-1:0] NOP_VAL = '0
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             we,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic [3:0]       occ,
  output logic [15:0]      stall_cnt
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            v_q, v_d;
  logic [3:0]                  occ_q, occ_d;

  always_comb begin
    data_d = data_q;
    v_d    = v_q;
    occ_d  = occ_q;
    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        data_d[i] = NOP_VAL;
      end
      v_d   = '0;
      occ_d = '0;
    end else if (!we) begin
      data_d[0] = d;
      v_d[0]    = d_valid;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        v_d[i]    = v_q[i-1];
      end
      // One entry enters at stage 0 and one leaves from the last stage.
      occ_d = occ_q + {3'b000, d_valid} - {3'b000, v_q[DEPTH-1]};
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      data_q <= '0;
      v_q    <= '0;
      occ_q  <= '0;
    end else begin
      data_q <= data_d;
      v_q    <= v_d;
      occ_q  <= occ_d;
    end
  end

  assign q       = data_q[DEPTH-1];
  assign q_valid = v_q[DEPTH-1];
  assign occ     = occ_q;

`ifdef PIPE_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (we && !flush && (occ_q != '0) && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Testbench for pipe_stage_chain (DEPTH=3, WIDTH=32, NOP_VAL=32'h13).
// The driver models the chain as a queue of stage entries and pushes the
// expected post-edge outputs into a scoreboard; a monitor pops and compares
// one entry after each rising edge.

module tb_pipe_stage_chain;

  localparam int unsigned     W   = 32;
  localparam int unsigned     D   = 3;
  localparam logic [W-1:0]    NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         clrn = 1'b0;
  logic         we = 1'b1;
  logic         flush = 1'b0;
  logic [W-1:0] d = '0;
  logic         d_valid = 1'b0;
  logic [W-1:0] q;
  logic         q_valid;
  logic [3:0]   occ;
  logic [15:0]  stall_cnt;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [W-1:0] q;
    logic         qv;
    logic [3:0]   occ;
    logic [15:0]  sc;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] m_data[$];   // index 0 = stage 0
  logic         m_v[$];
  logic [15:0]  m_stall;

  pipe_stage_chain #(
    .WIDTH   (W),
    .DEPTH   (D),
    .NOP_VAL (NOP)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .we        (we),
    .flush     (flush),
    .d         (d),
    .d_valid   (d_valid),
    .q         (q),
    .q_valid   (q_valid),
    .occ       (occ),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned model_occ();
    int unsigned n = 0;
    foreach (m_v[i]) if (m_v[i]) n++;
    return n;
  endfunction

  task automatic model_reset();
    m_data.delete();
    m_v.delete();
    for (int i = 0; i < int'(D); i++) begin
      m_data.push_back('0);
      m_v.push_back(1'b0);
    end
    m_stall = '0;
  endtask

  // One clock edge of stimulus; the expected result is queued for the monitor.
  task automatic step(input logic i_we, input logic i_fl, input logic i_dv,
                      input logic [W-1:0] i_d);
    exp_t e;
    int unsigned pre_occ;
    @(negedge clk);
    we = i_we; flush = i_fl; d_valid = i_dv; d = i_d;
    pre_occ = model_occ();
`ifdef PIPE_STALL_CNT_EN
    if (i_we && !i_fl && pre_occ != 0 && m_stall != 16'hFFFF) m_stall = m_stall + 16'd1;
`endif
    if (i_fl) begin
      foreach (m_data[i]) begin
        m_data[i] = NOP;
        m_v[i]    = 1'b0;
      end
    end else if (!i_we) begin
      m_data.push_front(i_d);
      m_v.push_front(i_dv);
      void'(m_data.pop_back());
      void'(m_v.pop_back());
    end
    e.q   = m_data[D-1];
    e.qv  = m_v[D-1];
    e.occ = 4'(model_occ());
    e.sc  = m_stall;
    exp_q.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: compares the DUT outputs after each edge against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("q",         64'(q),         64'(e.q));
        chk("q_valid",   64'(q_valid),   64'(e.qv));
        chk("occ",       64'(occ),       64'(e.occ));
        chk("stall_cnt", 64'(stall_cnt), 64'(e.sc));
      end
    end
  end

  initial begin
    model_reset();
    #1;
    chk("rst_q",     64'(q),         64'd0);
    chk("rst_qv",    64'(q_valid),   64'd0);
    chk("rst_occ",   64'(occ),       64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    repeat (2) @(negedge clk);
    clrn = 1'b1;

    // Alternating valid flags through the three-stage chain.
    step(1'b0, 1'b0, 1'b1, 32'h1111_1111);
    step(1'b0, 1'b0, 1'b0, 32'h2222_2222);
    step(1'b0, 1'b0, 1'b1, 32'h3333_3333);
    step(1'b0, 1'b0, 1'b0, 32'h4444_4444);
    step(1'b0, 1'b0, 1'b0, 32'h5555_5555);
    // Fill, then stall three edges.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, $urandom);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, $urandom);
    // Flush while stalled; d on this edge must never reach q.
    step(1'b1, 1'b1, 1'b1, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
    // Flush while advancing.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, $urandom);
    step(1'b0, 1'b1, 1'b1, 32'hCAFE_F00D);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), $urandom);
    end

    // Asynchronous reset between edges with a populated chain.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, $urandom);
    step(1'b1, 1'b0, 1'b1, $urandom);
    #3;
    clrn = 1'b0;
    #1;
    chk("arst_q",     64'(q),         64'd0);
    chk("arst_qv",    64'(q_valid),   64'd0);
    chk("arst_occ",   64'(occ),       64'd0);
    chk("arst_stall", 64'(stall_cnt), 64'd0);
    we = 1'b0; flush = 1'b0; d_valid = 1'b1; d = 32'hA5A5_A5A5;
    @(posedge clk);
    #1;
    chk("inrst_q",   64'(q),       64'd0);
    chk("inrst_qv",  64'(q_valid), 64'd0);
    chk("inrst_occ", 64'(occ),     64'd0);
    we = 1'b1; d_valid = 1'b0;
    @(negedge clk);
    clrn = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, $urandom);

    // Long stall: the counter must saturate rather than wrap.
    for (int i = 0; i < 65540; i++) step(1'b1, 1'b0, 1'b0, $urandom);
    step(1'b0, 1'b0, 1'b0, 32'h0);

    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stage_chain.md
PIPE_STAGE_CHAIN -- requirements
Module: pipe_stage_chain

Interface
REQ-001 Parameter WIDTH, default 32, data bits per stage (1..64).
REQ-002 Parameter DEPTH, default 2, number of register stages (1..8).
REQ-003 Parameter NOP_VAL, default 0, WIDTH-bit value loaded into every stage on flush.
REQ-004 clk  input  1  single clock; all state changes on posedge clk.
REQ-005 clrn  input  1  reset; asynchronous, active-low.
REQ-006 we  input  1  advance enable, active-low: 0 = advance chain, 1 = hold (stall).
REQ-007 flush  input  1  active-high; invalidates all stages.
REQ-008 d  input  WIDTH  data into stage 0.
REQ-009 d_valid  input  1  valid flag accompanying d.
REQ-010 q  output  WIDTH  data of stage DEPTH-1, registered.
REQ-011 q_valid  output  1  valid flag of stage DEPTH-1, registered.
REQ-012 occ  output  4  count of stages whose valid flag is 1 (0..DEPTH), registered.
REQ-013 stall_cnt  output  16  stall-cycle counter (see Configuration).

Function
REQ-014 Each stage i holds data[i] (WIDTH bits) and v[i] (1 bit); q = data[DEPTH-1], q_valid = v[DEPTH-1].
REQ-015 Advance (we=0, flush=0) at posedge clk: data[0]<=d, v[0]<=d_valid, and data[i]<=data[i-1], v[i]<=v[i-1] for i=1..DEPTH-1.
REQ-016 d is captured on advance regardless of d_valid; only v[] marks validity.
REQ-017 Latency d -> q is exactly DEPTH advancing edges; with DEPTH=1 the block behaves as a single write-enabled register with valid flag.
REQ-018 Hold (we=1, flush=0): every data[i], v[i] and occ retain their values.
REQ-019 Flush (flush=1) at posedge clk: every data[i]<=NOP_VAL, every v[i]<=0, occ<=0, irrespective of we and d_valid.
REQ-020 Simultaneous flush=1 and we=1: flush wins; d on that edge is discarded.
REQ-021 occ after every edge equals the number of 1s in v[] after that edge; on advance occ_next = occ + d_valid - v[DEPTH-1].
REQ-022 occ never exceeds DEPTH and never underflows; occ upper bits beyond clog2(DEPTH+1) are 0.
REQ-023 No combinational path from any input to any output.

Reset
REQ-024 clrn=0 immediately (without clk) forces all data[i]=0 (not NOP_VAL), all v[i]=0, occ=0, stall_cnt=0.
REQ-025 While clrn=0 all inputs are ignored; reset asserted mid-stream discards all in-flight entries.
REQ-026 First advance occurs on the first posedge clk with clrn=1 and we=0.

Configuration
REQ-027 Macro PIPE_STALL_CNT_EN controls the stall counter.
REQ-028 With PIPE_STALL_CNT_EN defined: stall_cnt increments by 1 on every posedge clk with we=1, flush=0 and occ!=0; saturates at 16'hFFFF; cleared only by reset.
REQ-029 Without PIPE_STALL_CNT_EN: stall_cnt is constant 0 and no counter logic is built; all other behaviour is identical.

Verification
REQ-030 DEPTH=2, WIDTH=32, we=0; d=32'h11111111 then 32'h22222222, d_valid=1 -> q=32'h11111111, q_valid=1 after edge 2, q=32'h22222222 after edge 3; occ=1,2,2.
REQ-031 Chain full (occ=2), we=1 for 3 edges -> q, q_valid and occ unchanged; with macro stall_cnt=3, without macro stall_cnt=0.
REQ-032 Chain full, NOP_VAL=32'h00000013, flush=1 with we=1 -> next edge q=32'h00000013, q_valid=0, occ=0; d on that edge never appears at q.
REQ-033 Alternating d_valid=1,0,1 with we=0, DEPTH=3 -> q_valid sequence 1,0,1 starting at edge 3; occ=1,1,2,2.
REQ-034 clrn pulsed low between clock edges with occ=2 -> q=0, q_valid=0, occ=0, stall_cnt=0 without waiting for clk.
REQ-035 With macro, hold we=1, occ!=0 for 65540 edges -> stall_cnt stays at 16'hFFFF, no wrap.
